noc_sequencer: RTL and testbench
================================

Name: noc_sequencer

Overview:
- Global control sequencer for the router mesh: one instance drives every router's `op` and `data` inputs and the shared `in_cycle` count.
- After `start` it performs these steps in order:
  - one Init broadcast;
  - routing-table loading, one entry per accepted config beat, sent to one target router;
  - repeated simulation rounds of Inject, LoadStaging, Phase0, Phase1 and Check.
- Runs stop after the mesh has been quiescent for DRAIN_ROUNDS consecutive rounds, or when the cycle budget is exhausted.

Parameters:
- NUM_ROUTERS, 16, number of routers driven; one op slot each.
- RIDX_W, 4, width of cfg_router; must satisfy 2^RIDX_W >= NUM_ROUTERS.
- MAX_CYCLE, 1000, in_cycle value at which the run is aborted with timeout.
- DRAIN_ROUNDS, 4, number of consecutive idle Check rounds required to finish; must be >= 1.

Ports:
- clk  in  1  system clock. Routers act on its negedge; this block updates on its posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- init_word  in  32  data broadcast with the Init op (credit delay field etc.).
- cfg_valid  in  1  a routing-entry beat is available.
- cfg_ready  out  1  the block accepts a beat this cycle.
- cfg_router  in  RIDX_W  target router index of the beat.
- cfg_data  in  32  routing entry (destination and out-port fields).
- cfg_last  in  1  marks the final routing beat.
- router_done  in  NUM_ROUTERS  `done` output of each router.
- inj_pending  in  1  the traffic source still holds flits to inject.
- inj_step  out  1  one-cycle pulse telling the traffic source to present this round's flits.
- op_bus  out  NUM_ROUTERS*`op_size  per-router op; slot i is bits [(i+1)*`op_size-1 : i*`op_size].
- data  out  `DataBitSize  shared data word for all routers.
- in_cycle  out  `in_cycle_size  current simulation cycle.
- busy  out  1  high in every state except IDLE and DONE.
- finished  out  1  sticky; set on normal completion.
- timeout  out  1  sticky; set when MAX_CYCLE is reached.
- cfg_err  out  1  sticky; set when a beat arrives with an out-of-range router index.

Behaviour:
- All outputs are registered. Op encodings come from parameters.v: `NOP, `Init, `LoadRt, `LoadStaging, `Phase0, `Phase1.
- Each non-NOP op is held for exactly one clk cycle. Routers sample it on the following negedge.
- Reset values: state IDLE; every op_bus slot `NOP; data 0; in_cycle 0; idle_cnt 0; cfg_ready, inj_step, busy, finished, timeout and cfg_err all 0.
- Reset asserted mid-run: state returns to IDLE and op_bus is all `NOP on the next cycle. A routing load in progress is abandoned; no beat is consumed in the reset cycle.
- IDLE / DONE:
  - op_bus is all `NOP.
  - On start: go to INIT and clear finished, timeout, cfg_err, in_cycle and idle_cnt.
- INIT (1 cycle):
  - All slots carry `Init; data = init_word.
  - Next state: LOAD_RT.
- LOAD_RT:
  - cfg_ready = 1.
  - When cfg_valid && cfg_ready, the beat is accepted. If cfg_router < NUM_ROUTERS, the next cycle has slot[cfg_router] = `LoadRt, data = cfg_data, and all other slots `NOP.
  - An out-of-range index consumes the beat, drives all `NOP and sets cfg_err.
  - cfg_ready drops for the cycle that issues the op, so there is at most one beat per 2 cycles.
  - An accepted beat with cfg_last: issue its op, then go to INJECT.
  - While cfg_valid is low, stay in LOAD_RT with all `NOP.
- INJECT (1 cycle): inj_step = 1, all `NOP. Next state: LOADSTG.
- LOADSTG, PH0, PH1 (1 cycle each): all slots `LoadStaging, `Phase0 and `Phase1 respectively; data = 0.
- CHECK (1 cycle):
  - All `NOP. router_done is sampled here; it reflects the Phase1 negedge.
  - quiet = &router_done && !inj_pending.
  - If quiet, idle_cnt increments; otherwise idle_cnt resets to 0.
  - If quiet and idle_cnt+1 == DRAIN_ROUNDS: go to DONE and set finished. in_cycle is not incremented.
  - Else if in_cycle == MAX_CYCLE: go to DONE and set timeout.
  - Else: in_cycle += 1 and go to INJECT.
  - If both conditions hold in the same CHECK, finished takes priority.
- Round length: 5 clk cycles.
- in_cycle is modulo 2^`in_cycle_size but never wraps, because MAX_CYCLE must be below 2^`in_cycle_size.
- start asserted while busy is ignored.

Test Plan:
- Reset/idle: hold rst for 3 cycles, then start = 0 for 10 cycles -> op_bus all `NOP, busy = 0, in_cycle = 0 throughout.
- Config load: start; 3 beats (router 2, 5, 15; last on the third) with cfg_valid held -> one `Init cycle with data = init_word, then `LoadRt appears only in slots 2, 5 and 15, each with its cfg_data, spaced 2 cycles apart; then INJECT.
- Drain: router_done all 1, inj_pending = 0, DRAIN_ROUNDS = 4 -> exactly 4 rounds of LoadStaging/Phase0/Phase1, finished = 1, in_cycle = 3, busy = 0.
- Activity resets drain: router 7 done = 0 in round 3 only -> idle_cnt resets; finished after round 7 with in_cycle = 6.
- Timeout: router_done = 0 permanently, MAX_CYCLE = 10 -> timeout = 1 at the CHECK where in_cycle = 10, finished = 0.
- Error and reset mid-run: beat with cfg_router = 20 (NUM_ROUTERS = 16) -> cfg_err = 1, no LoadRt issued. Then rst during PH0 -> the next cycle has IDLE, all `NOP, in_cycle = 0, cfg_err = 0.

Source files
------------

// File: rtl/noc_sequencer.sv
// noc_sequencer: global control sequencer for the router mesh.
// Drives per-router op slots, the shared data word and the simulation cycle
// count through Init, routing-table load and repeated simulation rounds.
// Every output is registered; each cycle's outputs are computed from the
// next state, so a state's op appears on op_bus while the FSM sits in it.

`ifndef OP_SIZE
`define OP_SIZE 3
`endif
`ifndef DataBitSize
`define DataBitSize 32
`endif
`ifndef IN_CYCLE_SIZE
`define IN_CYCLE_SIZE 16
`endif
`ifndef NOP
`define NOP 3'd0
`endif
`ifndef Init
`define Init 3'd1
`endif
`ifndef LoadRt
`define LoadRt 3'd2
`endif
`ifndef LoadStaging
`define LoadStaging 3'd3
`endif
`ifndef Phase0
`define Phase0 3'd4
`endif
`ifndef Phase1
`define Phase1 3'd5
`endif

module noc_sequencer #(
  parameter int unsigned NUM_ROUTERS  = 16,
  parameter int unsigned RIDX_W       = 4,
  parameter int unsigned MAX_CYCLE    = 1000,
  parameter int unsigned DRAIN_ROUNDS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [31:0]                       init_word,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [RIDX_W-1:0]                 cfg_router,
  input  logic [31:0]                       cfg_data,
  input  logic                              cfg_last,
  input  logic [NUM_ROUTERS-1:0]            router_done,
  input  logic                              inj_pending,
  output logic                              inj_step,
  output logic [NUM_ROUTERS*`OP_SIZE-1:0]   op_bus,
  output logic [`DataBitSize-1:0]           data,
  output logic [`IN_CYCLE_SIZE-1:0]         in_cycle,
  output logic                              busy,
  output logic                              finished,
  output logic                              timeout,
  output logic                              cfg_err
);

  localparam int unsigned OPS    = `OP_SIZE;
  localparam int unsigned DW     = `DataBitSize;
  localparam int unsigned IC_W   = `IN_CYCLE_SIZE;
  localparam int unsigned OB_W   = NUM_ROUTERS * OPS;
  localparam int unsigned IDLE_W = $clog2(DRAIN_ROUNDS + 1);

  localparam logic [IC_W-1:0]   MAX_C    = IC_W'(MAX_CYCLE);
  localparam logic [IDLE_W:0]   DRAIN_C  = (IDLE_W + 1)'(DRAIN_ROUNDS);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LOAD_RT, S_LOAD_ISS, S_INJECT,
    S_LOADSTG, S_PH0, S_PH1, S_CHECK, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [OB_W-1:0]   r_op_bus, w_op_nxt;
  logic [DW-1:0]     r_data, w_data_nxt;
  logic [IC_W-1:0]   r_in_cycle, w_in_cycle_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
  logic              r_cfg_ready, w_ready_nxt;
  logic              r_inj_step, w_inj_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_finished, w_fin_nxt;
  logic              r_timeout, w_to_nxt;
  logic              r_cfg_err, w_err_nxt;
  logic              r_last, w_last_nxt;
  logic              w_quiet, w_in_range, w_drained;

  function automatic logic [OB_W-1:0] bcast(input logic [OPS-1:0] op);
    logic [OB_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_ROUTERS; i++) v[i*OPS +: OPS] = op;
    return v;
  endfunction

  assign w_quiet    = (&router_done) && !inj_pending;
  assign w_in_range = (32'(cfg_router) < NUM_ROUTERS);
  assign w_drained  = w_quiet && (({1'b0, r_idle_cnt} + (IDLE_W + 1)'(1)) == DRAIN_C);

  // Next-state and next-output computation; outputs follow the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = bcast(OPS'(`NOP));
    w_data_nxt     = '0;
    w_in_cycle_nxt = r_in_cycle;
    w_idle_nxt     = r_idle_cnt;
    w_ready_nxt    = 1'b0;
    w_inj_nxt      = 1'b0;
    w_fin_nxt      = r_finished;
    w_to_nxt       = r_timeout;
    w_err_nxt      = r_cfg_err;
    w_last_nxt     = r_last;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt    = S_INIT;
          w_op_nxt       = bcast(OPS'(`Init));
          w_data_nxt     = DW'(init_word);
          w_fin_nxt      = 1'b0;
          w_to_nxt       = 1'b0;
          w_err_nxt      = 1'b0;
          w_in_cycle_nxt = '0;
          w_idle_nxt     = '0;
        end
      end
      S_INIT: begin
        w_state_nxt = S_LOAD_RT;
        w_ready_nxt = 1'b1;
      end
      S_LOAD_RT: begin
        if (cfg_valid && r_cfg_ready) begin
          // Issue cycle lives in its own state so cfg_ready drops for it.
          w_state_nxt = S_LOAD_ISS;
          w_last_nxt  = cfg_last;
          if (w_in_range) begin
            for (int unsigned i = 0; i < NUM_ROUTERS; i++)
              if (32'(cfg_router) == i) w_op_nxt[i*OPS +: OPS] = OPS'(`LoadRt);
            w_data_nxt = DW'(cfg_data);
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_LOAD_ISS: begin
        if (r_last) begin
          w_state_nxt = S_INJECT;
          w_inj_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_LOAD_RT;
          w_ready_nxt = 1'b1;
        end
      end
      S_INJECT: begin
        w_state_nxt = S_LOADSTG;
        w_op_nxt    = bcast(OPS'(`LoadStaging));
      end
      S_LOADSTG: begin
        w_state_nxt = S_PH0;
        w_op_nxt    = bcast(OPS'(`Phase0));
      end
      S_PH0: begin
        w_state_nxt = S_PH1;
        w_op_nxt    = bcast(OPS'(`Phase1));
      end
      S_PH1: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_idle_nxt = w_quiet ? r_idle_cnt + IDLE_W'(1) : '0;
        if (w_drained) begin
          w_state_nxt = S_DONE;
          w_fin_nxt   = 1'b1;
        end else if (r_in_cycle == MAX_C) begin
          w_state_nxt = S_DONE;
          w_to_nxt    = 1'b1;
        end else begin
          w_in_cycle_nxt = r_in_cycle + IC_W'(1);
          w_state_nxt    = S_INJECT;
          w_inj_nxt      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_bus    <= bcast(OPS'(`NOP));
      r_data      <= '0;
      r_in_cycle  <= '0;
      r_idle_cnt  <= '0;
      r_cfg_ready <= 1'b0;
      r_inj_step  <= 1'b0;
      r_busy      <= 1'b0;
      r_finished  <= 1'b0;
      r_timeout   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op_bus    <= w_op_nxt;
      r_data      <= w_data_nxt;
      r_in_cycle  <= w_in_cycle_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_cfg_ready <= w_ready_nxt;
      r_inj_step  <= w_inj_nxt;
      r_busy      <= w_busy_nxt;
      r_finished  <= w_fin_nxt;
      r_timeout   <= w_to_nxt;
      r_cfg_err   <= w_err_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign inj_step  = r_inj_step;
  assign op_bus    = r_op_bus;
  assign data      = r_data;
  assign in_cycle  = r_in_cycle;
  assign busy      = r_busy;
  assign finished  = r_finished;
  assign timeout   = r_timeout;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_noc_sequencer.sv
// tb_noc_sequencer: directed bench for noc_sequencer with an op scoreboard.
// Expected ops (value, data, spacing) are queued as stimulus is issued and
// compared by a negedge monitor whenever op_bus carries a non-NOP op.

`ifndef OP_SIZE
`define OP_SIZE 3
`endif
`ifndef DataBitSize
`define DataBitSize 32
`endif
`ifndef IN_CYCLE_SIZE
`define IN_CYCLE_SIZE 16
`endif
`ifndef NOP
`define NOP 3'd0
`endif
`ifndef Init
`define Init 3'd1
`endif
`ifndef LoadRt
`define LoadRt 3'd2
`endif
`ifndef LoadStaging
`define LoadStaging 3'd3
`endif
`ifndef Phase0
`define Phase0 3'd4
`endif
`ifndef Phase1
`define Phase1 3'd5
`endif

module tb_noc_sequencer;

  localparam int unsigned NR   = 16;
  localparam int unsigned RW   = 5;
  localparam int unsigned MAXC = 10;
  localparam int unsigned DR   = 4;
  localparam int unsigned OPS  = `OP_SIZE;
  localparam int unsigned OW   = NR * OPS;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic [31:0]               init_word = '0;
  logic                      cfg_valid = 1'b0;
  logic                      cfg_ready;
  logic [RW-1:0]             cfg_router = '0;
  logic [31:0]               cfg_data = '0;
  logic                      cfg_last = 1'b0;
  logic [NR-1:0]             router_done;
  logic                      inj_pending = 1'b0;
  logic                      inj_step;
  logic [OW-1:0]             op_bus;
  logic [`DataBitSize-1:0]   data;
  logic [`IN_CYCLE_SIZE-1:0] in_cycle;
  logic                      busy, finished, timeout, cfg_err;

  typedef struct {
    string         tag;
    logic [OW-1:0] op;
    logic [31:0]   data;
    int            gap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_op_cyc = 0;
  int   inj_cnt = 0;
  int   done_mode = 0;

  noc_sequencer #(
    .NUM_ROUTERS (NR),
    .RIDX_W      (RW),
    .MAX_CYCLE   (MAXC),
    .DRAIN_ROUNDS(DR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_word  (init_word),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_router (cfg_router),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .router_done(router_done),
    .inj_pending(inj_pending),
    .inj_step   (inj_step),
    .op_bus     (op_bus),
    .data       (data),
    .in_cycle   (in_cycle),
    .busy       (busy),
    .finished   (finished),
    .timeout    (timeout),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // mode 0: all done; mode 1: router 7 busy during round 3 only; mode 2: never done
  assign router_done = (done_mode == 2) ? '0 :
                       ((done_mode == 1) && (inj_cnt == 3)) ? 16'hFF7F : '1;

  function automatic logic [OW-1:0] bcast(input logic [OPS-1:0] op);
    logic [OW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NR); i++) v[i*OPS +: OPS] = op;
    return v;
  endfunction

  function automatic logic [OW-1:0] slot(input int idx, input logic [OPS-1:0] op);
    logic [OW-1:0] v;
    v = '0;
    v[idx*OPS +: OPS] = op;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [OW-1:0] op, input logic [31:0] d, input int gap);
    exp_t e;
    e.tag = tag; e.op = op; e.data = d; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_round(input int gap);
    push("loadstg", bcast(OPS'(`LoadStaging)), 32'h0, gap);
    push("phase0",  bcast(OPS'(`Phase0)),      32'h0, 1);
    push("phase1",  bcast(OPS'(`Phase1)),      32'h0, 1);
  endtask

  // Scoreboard monitor: every non-NOP op cycle must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (inj_step === 1'b1) inj_cnt++;
    if (op_bus !== '0) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_op: observed op_bus=%0h expected=no op", op_bus);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_op"}, 64'(op_bus), 64'(e.op));
        chk({e.tag, "_data"}, 64'(data), 64'(e.data));
        if (e.gap > 0) chk({e.tag, "_gap"}, 64'(cyc - last_op_cyc), 64'(e.gap));
      end
      last_op_cyc = cyc;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [RW-1:0] r, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_router = r; cfg_data = d; cfg_last = l;
    while (cfg_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept_wait", 64'(n < 20), 64'(1));
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("run_end_wait", 64'(n < 300), 64'(1));
  endtask

  initial begin
    int n;
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_op_bus",    64'(op_bus),    64'(0));
    chk("rst_data",      64'(data),      64'(0));
    chk("rst_in_cycle",  64'(in_cycle),  64'(0));
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(0));
    chk("rst_inj_step",  64'(inj_step),  64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_finished",  64'(finished),  64'(0));
    chk("rst_timeout",   64'(timeout),   64'(0));
    chk("rst_cfg_err",   64'(cfg_err),   64'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_op_bus",   64'(op_bus),   64'(0));
      chk("idle_busy",     64'(busy),     64'(0));
      chk("idle_in_cycle", 64'(in_cycle), 64'(0));
    end

    // Config load then drain after exactly DR quiet rounds
    done_mode = 0; inj_cnt = 0; init_word = 32'hC0DE_0042;
    push("init", bcast(OPS'(`Init)), 32'hC0DE_0042, -1);
    push("ldrt2",  slot(2,  OPS'(`LoadRt)), 32'hA000_0002, 2);
    push("ldrt5",  slot(5,  OPS'(`LoadRt)), 32'hA000_0005, 2);
    push("ldrt15", slot(15, OPS'(`LoadRt)), 32'hA000_000F, 2);
    push_round(2);
    for (int i = 1; i < int'(DR); i++) push_round(3);
    pulse_start();
    chk("run_busy", 64'(busy), 64'(1));
    send_beat(5'd2,  32'hA000_0002, 1'b0);
    send_beat(5'd5,  32'hA000_0005, 1'b0);
    send_beat(5'd15, 32'hA000_000F, 1'b1);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    wait_done();
    chk("drain_finished", 64'(finished), 64'(1));
    chk("drain_timeout",  64'(timeout),  64'(0));
    chk("drain_in_cycle", 64'(in_cycle), 64'(3));
    chk("drain_rounds",   64'(inj_cnt),  64'(4));
    chk("drain_sb_empty", 64'(sb.size()), 64'(0));
    chk("drain_cfg_err",  64'(cfg_err),  64'(0));

    // Activity in round 3 restarts the quiet count
    done_mode = 1; inj_cnt = 0; init_word = 32'h0000_1234;
    push("init", bcast(OPS'(`Init)), 32'h0000_1234, -1);
    push("ldrt0", slot(0, OPS'(`LoadRt)), 32'h1111_0000, 2);
    push_round(2);
    for (int i = 1; i < 7; i++) push_round(3);
    pulse_start();
    send_beat(5'd0, 32'h1111_0000, 1'b1);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    wait_done();
    chk("act_finished", 64'(finished), 64'(1));
    chk("act_timeout",  64'(timeout),  64'(0));
    chk("act_in_cycle", 64'(in_cycle), 64'(6));
    chk("act_rounds",   64'(inj_cnt),  64'(7));
    chk("act_sb_empty", 64'(sb.size()), 64'(0));

    // Never quiet: timeout at in_cycle == MAXC
    done_mode = 2; inj_cnt = 0; init_word = 32'hFFFF_0000;
    push("init", bcast(OPS'(`Init)), 32'hFFFF_0000, -1);
    push("ldrt3", slot(3, OPS'(`LoadRt)), 32'h3333_3333, 2);
    push_round(2);
    for (int i = 1; i <= int'(MAXC); i++) push_round(3);
    pulse_start();
    chk("restart_finished_clr", 64'(finished), 64'(0));
    send_beat(5'd3, 32'h3333_3333, 1'b1);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    wait_done();
    chk("to_timeout",  64'(timeout),  64'(1));
    chk("to_finished", 64'(finished), 64'(0));
    chk("to_in_cycle", 64'(in_cycle), 64'(MAXC));
    chk("to_rounds",   64'(inj_cnt),  64'(MAXC + 1));
    chk("to_busy",     64'(busy),     64'(0));
    chk("to_sb_empty", 64'(sb.size()), 64'(0));

    // Out-of-range beat, then reset during PH0
    done_mode = 0; inj_cnt = 0; init_word = 32'h5555_AAAA;
    push("init", bcast(OPS'(`Init)), 32'h5555_AAAA, -1);
    push("err_loadstg", bcast(OPS'(`LoadStaging)), 32'h0, 4);
    push("err_phase0",  bcast(OPS'(`Phase0)),      32'h0, 1);
    pulse_start();
    chk("restart_timeout_clr", 64'(timeout), 64'(0));
    send_beat(5'd20, 32'hDEAD_BEEF, 1'b1);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    chk("err_cfg_err", 64'(cfg_err), 64'(1));
    chk("err_no_ldrt", 64'(op_bus),  64'(0));
    n = 0;
    while (op_bus !== bcast(OPS'(`Phase0)) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ph0_wait", 64'(n < 30), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_op_bus",   64'(op_bus),   64'(0));
    chk("mid_rst_busy",     64'(busy),     64'(0));
    chk("mid_rst_in_cycle", 64'(in_cycle), 64'(0));
    chk("mid_rst_cfg_err",  64'(cfg_err),  64'(0));
    chk("mid_rst_data",     64'(data),     64'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy",     64'(busy),      64'(0));
    chk("post_rst_sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
